mc_mem_port: RTL and testbench

Unified instruction/data memory port for the multicycle core; the responder side of the control FSM's memory controls (IorD, MemWrite, IRWrite). Accepts one word request at a time, inserts optional wait states, and commits writes or returns read data. Returns read data through a registered Memory Data Register (MDR) and Instruction Register (IR), and drives the 6-bit OP field back to the control FSM. Sits between the control FSM/datapath and the word memory array it owns.

---
 rtl/mc_mem_pkg.sv | 24 ++
 rtl/mc_wait_counter.sv | 26 ++
 rtl/mc_mem_port.sv | 145 ++++++++++++++
 tb/tb_mc_mem_port.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multicycle core memory port and control FSM.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  function automatic logic [5:0] opcode_of(input logic [WORD_W-1:0] insn);
    return insn[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; load takes effect next cycle.
// Latency 1 cycle from load/dec to count; no backpressure, stops at zero.
module mc_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mc_mem_port.sv
// Unified I/D word memory port; one access in flight, ready 1+WAIT cycles after accept
// (WAIT only with MEM_WAIT_EN defined); requests are ignored while busy, no queueing.
module mc_mem_port
  import mc_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              iord,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic              addr_err,
  output logic [WORD_W-1:0] mdr,
  output logic [WORD_W-1:0] ir,
  output logic [5:0]        op
);

  localparam int AW = $clog2(DEPTH);

`ifdef MEM_WAIT_EN
  localparam int WAIT_EFF = WAIT;
`else
  // Wait states are compiled out; WAIT has no effect in this build.
  localparam int WAIT_EFF = WAIT * 0;
`endif
  localparam bit NO_WAIT = (WAIT_EFF == 0);

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic              irw_q;
  logic              cnt_zero;

  logic              accept;
  logic              commit;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic              c_we;
  logic              c_irw;
  logic              c_inr;
  logic [AW-1:0]     c_idx;
  logic [WORD_W-1:0] rd_word;

  assign accept = (state == ST_IDLE) && req;

  // Zero-wait accesses commit on the accepting edge, so they use the live inputs.
  always_comb begin
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_we    = we_q;
    c_irw   = irw_q;
    if (state == ST_IDLE) begin
      c_addr  = iord ? alu_out : pc;
      c_wdata = wdata;
      c_we    = mem_write;
      c_irw   = ir_write;
    end
  end

  assign commit  = (accept && NO_WAIT) || ((state == ST_WAIT) && cnt_zero);
  assign c_inr   = (c_addr < WORD_W'(DEPTH * 4));
  assign c_idx   = c_addr[AW+1:2];
  assign rd_word = c_inr ? mem[c_idx] : '0;

`ifdef MEM_WAIT_EN
  mc_wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (NO_WAIT ? 4'd0 : 4'(WAIT_EFF - 1)),
    .dec      (state == ST_WAIT),
    .zero     (cnt_zero)
  );
`else
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
      mdr      <= '0;
      ir       <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      irw_q    <= 1'b0;
    end else begin
      ready    <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= c_addr;
            wdata_q <= wdata;
            we_q    <= mem_write;
            irw_q   <= ir_write;
            busy    <= 1'b1;
            state   <= NO_WAIT ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_zero) state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      if (commit) begin
        ready    <= 1'b1;
        addr_err <= ~c_inr;
        if (!c_we) begin
          mdr <= rd_word;
          if (c_irw) ir <= rd_word;
        end
      end
    end
  end

  // Array is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && c_inr) mem[c_idx] <= c_wdata;
  end

  assign op = opcode_of(ir);

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed bench for mc_mem_port; latency expectations follow MEM_WAIT_EN.
module tb_mc_mem_port;
  import mc_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;
`ifdef MEM_WAIT_EN
  localparam int LAT = 1 + WAIT;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, iord, mem_write, ir_write;
  logic [31:0] pc, alu_out, wdata;
  logic        ready, busy, addr_err;
  logic [31:0] mdr, ir;
  logic [5:0]  op;

  int checks = 0;
  int errors = 0;
  logic err_seen;

  mc_mem_port #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .iord      (iord),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .ready     (ready),
    .busy      (busy),
    .addr_err  (addr_err),
    .mdr       (mdr),
    .ir        (ir),
    .op        (op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request pulse; waits for ready (bounded), checks latency and pulse width.
  task automatic access(input string tag, input logic io, input logic we, input logic irw,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    iord = io; mem_write = we; ir_write = irw; pc = p; alu_out = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_at_ready"}, 32'(busy), 32'd1);
    err_seen = addr_err;
    @(negedge clk);
    chk({tag, "_ready_1cyc"}, 32'(ready), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; req = 1'b0; iord = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    pc = '0; alu_out = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_op", 32'(op), 32'd0);

    // Preload through the port; ir_write on a write must not touch ir.
    access("pre0", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h1111_1111);
    access("pre1", 1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h8C22_0004);
    access("pre8", 1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'hAAAA_5555);
    chk("pre_ir_untouched", ir, 32'd0);
    chk("pre_mdr_untouched", mdr, 32'd0);

    access("fetch", 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0);
    chk("fetch_ir", ir, 32'h8C22_0004);
    chk("fetch_mdr", mdr, 32'h8C22_0004);
    chk("fetch_op", 32'(op), 32'(OP_LW));
    chk("fetch_err", 32'(err_seen), 32'd0);

    access("store", 1'b1, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF);
    chk("store_ir", ir, 32'h8C22_0004);
    chk("store_mdr", mdr, 32'h8C22_0004);
    access("load", 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0);
    chk("load_mdr", mdr, 32'hDEAD_BEEF);
    chk("load_ir", ir, 32'h8C22_0004);

    access("oor_wr", 1'b1, 1'b1, 1'b0, 32'h0, 32'h400, 32'h1234_5678);
    chk("oor_wr_err", 32'(err_seen), 32'd1);
    access("oor_rd", 1'b1, 1'b0, 1'b1, 32'h0, 32'h400, 32'h0);
    chk("oor_rd_err", 32'(err_seen), 32'd1);
    chk("oor_rd_mdr", mdr, 32'd0);
    chk("oor_rd_ir", ir, 32'd0);
    access("oor_chk0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("oor_mem0_kept", mdr, 32'h1111_1111);
    chk("inr_err", 32'(err_seen), 32'd0);

    // Second request held through the busy cycle must be ignored.
    pulses = 0;
    @(negedge clk);
    iord = 1'b1; mem_write = 1'b0; ir_write = 1'b0; alu_out = 32'h0; req = 1'b1;
    @(negedge clk);
    pulses += int'(ready);
    alu_out = 32'h10;
    @(negedge clk);
    pulses += int'(ready);
    req = 1'b0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(ready);
    end
    chk("busy_pulses", 32'(pulses), 32'd1);
    chk("busy_mdr", mdr, 32'h1111_1111);

    // Reset while a write to 0x20 is in flight.
    pulses = 0;
    @(negedge clk);
    iord = 1'b1; mem_write = 1'b1; ir_write = 1'b1; alu_out = 32'h20;
    wdata = 32'hBAD0_BAD0; req = 1'b1;
    if (LAT > 1) begin
      @(negedge clk);
      req = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    pulses += int'(ready);
    req = 1'b0; rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(ready);
    end
    chk("rstmid_pulses", 32'(pulses), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_mdr", mdr, 32'd0);
    chk("rstmid_ir", ir, 32'd0);
    access("rstmid_rd", 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0);
    chk("rstmid_mem8", mdr, 32'hAAAA_5555);

    access("unal", 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 32'h0);
    chk("unal_ir", ir, 32'h8C22_0004);
    chk("unal_op", 32'(op), 32'(OP_LW));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
